fpu_rf_sequencer: RTL and testbench
===================================

# fpu_rf_sequencer

Client-side controller for the floating-point register file interface: the block that drives `f_rs1`/`f_rs2`/`f_rd`/`f_w_data`/`f_wen`/exception flags into the FP register file and consumes `f_rs1_data`/`f_rs2_data`/`f_frm_out`. It accepts one FP instruction at a time and reads its operands. It resolves the rounding mode, launches a multi-cycle FPU execute unit, waits for completion and writes the result and accrued-exception flags back. It sits between FP decode/issue and the FPU datapath.

## Interface
- TIMEOUT_CYCLES, 64, watchdog limit in EXEC cycles; used only with the watchdog macro; must be ≥2.
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  high only in IDLE.
- issue_op  in  4  FPU opcode, forwarded untouched.
- issue_rs1, issue_rs2, issue_rd  in  5 each  FP register indices; f0 is a real register, with no x0 semantics.
- issue_rm  in  3  instruction rm field; 3'b111 = dynamic.
- f_rs1, f_rs2  out  5 each  RF read indices.
- f_rs1_data, f_rs2_data  in  32 each  combinational RF read data.
- f_frm_out  in  3  current frm.
- f_frm_in  out  3  driven equal to `f_frm_out`; this block never changes frm.
- exe_start  out  1  one-cycle launch pulse.
- exe_op  out  4  latched opcode.
- exe_a, exe_b  out  32 each  latched operands.
- exe_rm  out  3  resolved rounding mode.
- exe_done  in  1  result valid.
- exe_result  in  32  result value.
- exe_flags  in  5  {NV,DZ,OF,UF,NX}.
- f_rd  out  5  writeback index.
- f_w_data  out  32  writeback data.
- f_wen  out  1  writeback strobe.
- f_NV, f_DZ, f_OF, f_UF, f_NX  out  1 each  accrued flags; valid only with `f_wen`.
- illegal_rm  out  1  one-cycle pulse when the resolved rm is reserved.
- exe_timeout  out  1  one-cycle watchdog pulse.
- busy  out  1  high when not in IDLE.

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: `issue_ready`=1. On `issue_valid` the block latches op, rs1, rs2, rd and rm, then moves to READ.
- READ: drives `f_rs1`/`f_rs2` from the latched indices and registers `f_rs1_data`/`f_rs2_data` into `exe_a`/`exe_b`.
  - Resolved rm = `f_frm_out` if the latched rm is 3'b111, else the latched rm.
  - If the resolved rm is 5, 6 or 7: pulse `illegal_rm`, return to IDLE, and make no RF write.
  - Otherwise go to EXEC.
- EXEC: `exe_start`=1 on the first EXEC cycle only. `exe_a`/`exe_b`/`exe_op`/`exe_rm` stay stable throughout. `exe_done` is honoured on any EXEC cycle, including the first. On done, latch `exe_result`/`exe_flags` and go to WB.
- WB: for one cycle, `f_wen`=1, `f_rd`=latched rd, `f_w_data`=latched result, and the flags equal the latched `exe_flags`. Then go to IDLE.
- `f_rs1`/`f_rs2` hold their last value outside READ. `f_rd`, `f_w_data` and the flags are 0 when `f_wen`=0.
- `exe_done` outside EXEC is ignored.

## Timing
- Reset values: FSM=IDLE, `issue_ready`=1, and every other output = 0. `f_frm_in` follows `f_frm_out`.
- Reset mid-operation aborts asynchronously: no write, no pulse. The execute unit shares nRST.
- Handshake cycle 0, READ cycle 1, EXEC from cycle 2, WB the cycle after `exe_done`. With done in the first EXEC cycle, `f_wen` is high in cycle 3.
- `issue_ready` returns the cycle after WB, illegal-rm abort or timeout. Peak throughput is one instruction per 4 cycles.
- RF read is combinational. No RF write overlaps a READ of the same instruction.

## Configuration
- `FPU_RF_SEQ_WATCHDOG_EN` defined:
  - An EXEC cycle counter starts at 0 on EXEC entry.
  - If `exe_done` is still low in the cycle the count equals TIMEOUT_CYCLES-1, pulse `exe_timeout` in the next cycle, return to IDLE, and make no RF write.
  - `exe_done` in the expiry cycle wins: normal WB, no timeout.
- Not defined: the counter is absent, `exe_timeout` is tied to 0, and EXEC waits indefinitely.

## Test plan
- Reset with all inputs 0 -> `issue_ready`=1, `f_wen`=0, `busy`=0, `exe_start`=0.
- Issue rs1=3, rs2=4, rd=0, rm=3'b001 with `exe_done` returning 0x3F800000, flags 5'b00001, 2 cycles after `exe_start` -> single `f_wen` pulse with `f_rd`=0, `f_w_data`=0x3F800000, `f_NX`=1; `exe_start` high exactly 1 cycle.
- rm=3'b111 with `f_frm_out`=3'b010 -> `exe_rm`=3'b010. Repeat with `f_frm_out`=3'b101 -> `illegal_rm` pulse, no `f_wen`, back to IDLE.
- `exe_done` high on the first EXEC cycle -> `f_wen` in cycle 3 after the handshake. `issue_valid` held high continuously -> a new accept every 4 cycles.
- Drop nRST during EXEC -> all outputs 0 immediately; no `f_wen` after release; `issue_ready`=1.
- Watchdog build, TIMEOUT_CYCLES=4:
  - `exe_done` never asserted -> `exe_timeout` pulse after 4 EXEC cycles, no write.
  - `exe_done` on EXEC cycle 4 -> normal WB, `exe_timeout`=0.

Source files
------------

// File: rtl/fpu_rf_sequencer.sv
// Sequences one FP instruction through operand read, FPU execute and RF writeback.
// Optional EXEC watchdog: define FPU_RF_SEQ_WATCHDOG_EN (limit = TIMEOUT_CYCLES, >= 2).
module fpu_rf_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [3:0]  issue_op,
   input  logic [4:0]  issue_rs1,
   input  logic [4:0]  issue_rs2,
   input  logic [4:0]  issue_rd,
   input  logic [2:0]  issue_rm,
   output logic [4:0]  f_rs1,
   output logic [4:0]  f_rs2,
   input  logic [31:0] f_rs1_data,
   input  logic [31:0] f_rs2_data,
   input  logic [2:0]  f_frm_out,
   output logic [2:0]  f_frm_in,
   output logic        exe_start,
   output logic [3:0]  exe_op,
   output logic [31:0] exe_a,
   output logic [31:0] exe_b,
   output logic [2:0]  exe_rm,
   input  logic        exe_done,
   input  logic [31:0] exe_result,
   input  logic [4:0]  exe_flags,
   output logic [4:0]  f_rd,
   output logic [31:0] f_w_data,
   output logic        f_wen,
   output logic        f_NV,
   output logic        f_DZ,
   output logic        f_OF,
   output logic        f_UF,
   output logic        f_NX,
   output logic        illegal_rm,
   output logic        exe_timeout,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t      state;
   logic [4:0]  rd_q;
   logic [2:0]  rm_q;
   logic [4:0]  flags_q;
   logic [2:0]  rm_res;
   logic        wd_exp;

   assign issue_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign f_frm_in    = f_frm_out;
   assign {f_NV, f_DZ, f_OF, f_UF, f_NX} = flags_q;

   // rm 3'b111 defers to the dynamic frm; 5..7 after resolution are reserved
   always_comb rm_res = (rm_q == 3'b111) ? f_frm_out : rm_q;

`ifdef FPU_RF_SEQ_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] wd_cnt;

   assign wd_exp = (state == EXEC) && !exe_done && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wd_cnt      <= '0;
         exe_timeout <= 1'b0;
      end else begin
         exe_timeout <= wd_exp;
         if (state == READ)      wd_cnt <= '0;
         else if (state == EXEC) wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign wd_exp      = 1'b0;
   assign exe_timeout = 1'b0;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         rd_q       <= '0;
         rm_q       <= '0;
         f_rs1      <= '0;
         f_rs2      <= '0;
         exe_start  <= 1'b0;
         exe_op     <= '0;
         exe_a      <= '0;
         exe_b      <= '0;
         exe_rm     <= '0;
         f_rd       <= '0;
         f_w_data   <= '0;
         f_wen      <= 1'b0;
         flags_q    <= '0;
         illegal_rm <= 1'b0;
      end else begin
         illegal_rm <= 1'b0;
         case (state)
            IDLE: if (issue_valid) begin
               // read indices load here so they are already on the RF port during READ
               f_rs1  <= issue_rs1;
               f_rs2  <= issue_rs2;
               rd_q   <= issue_rd;
               rm_q   <= issue_rm;
               exe_op <= issue_op;
               state  <= READ;
            end
            READ: begin
               exe_a <= f_rs1_data;
               exe_b <= f_rs2_data;
               if (rm_res >= 3'd5) begin
                  illegal_rm <= 1'b1;
                  state      <= IDLE;
               end else begin
                  exe_rm    <= rm_res;
                  exe_start <= 1'b1;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               exe_start <= 1'b0;
               if (exe_done) begin
                  f_wen    <= 1'b1;
                  f_rd     <= rd_q;
                  f_w_data <= exe_result;
                  flags_q  <= exe_flags;
                  state    <= WB;
               end else if (wd_exp) begin
                  state <= IDLE;
               end
            end
            WB: begin
               f_wen    <= 1'b0;
               f_rd     <= '0;
               f_w_data <= '0;
               flags_q  <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_rf_sequencer.sv
// Directed bench for fpu_rf_sequencer; define FPU_RF_SEQ_WATCHDOG_EN to cover the watchdog.
module tb_fpu_rf_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_ready;
   logic [3:0]  issue_op;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic [2:0]  issue_rm;
   logic [4:0]  f_rs1, f_rs2, f_rd;
   logic [31:0] f_rs1_data, f_rs2_data, f_w_data;
   logic [2:0]  f_frm_out, f_frm_in, exe_rm;
   logic        exe_start, exe_done, f_wen;
   logic [3:0]  exe_op;
   logic [31:0] exe_a, exe_b, exe_result;
   logic [4:0]  exe_flags;
   logic        f_NV, f_DZ, f_OF, f_UF, f_NX;
   logic        illegal_rm, exe_timeout, busy;

   int n_vec = 0;
   int n_err = 0;
   int wen_cnt = 0;
   int start_cnt = 0;
   int snap_w, snap_s;

   always #5 clk = ~clk;

   // register file model: read data encodes the index
   assign f_rs1_data = 32'hA000_0000 | {27'd0, f_rs1};
   assign f_rs2_data = 32'hB000_0000 | {27'd0, f_rs2};

   always @(negedge clk) begin
      if (f_wen)     wen_cnt++;
      if (exe_start) start_cnt++;
   end

   fpu_rf_sequencer #(.TIMEOUT_CYCLES(4)) dut (
      .CLK(clk), .nRST(rst_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_rm(issue_rm),
      .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rs1_data(f_rs1_data), .f_rs2_data(f_rs2_data),
      .f_frm_out(f_frm_out), .f_frm_in(f_frm_in),
      .exe_start(exe_start), .exe_op(exe_op), .exe_a(exe_a), .exe_b(exe_b), .exe_rm(exe_rm),
      .exe_done(exe_done), .exe_result(exe_result), .exe_flags(exe_flags),
      .f_rd(f_rd), .f_w_data(f_w_data), .f_wen(f_wen),
      .f_NV(f_NV), .f_DZ(f_DZ), .f_OF(f_OF), .f_UF(f_UF), .f_NX(f_NX),
      .illegal_rm(illegal_rm), .exe_timeout(exe_timeout), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // present one instruction and take the accept edge; caller then sits in READ
   task automatic issue(input logic [3:0] op, input logic [4:0] rs1, rs2, rd, input logic [2:0] rm);
      issue_valid = 1'b1;
      issue_op = op; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_rm = rm;
      chk("accept_ready", issue_ready, 1);
      tick;
      issue_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      issue_valid = 0; issue_op = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rm = 0;
      f_frm_out = 0; exe_done = 0; exe_result = 0; exe_flags = 0;
      #12;
      chk("rst_ready", issue_ready, 1);
      chk("rst_wen", f_wen, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", exe_start, 0);
      chk("rst_tmo", exe_timeout, 0);
      chk("rst_wdata", f_w_data, 0);
      f_frm_out = 3'b011;
      #1 chk("frm_follow", f_frm_in, 3'b011);
      f_frm_out = 3'b000;
      @(negedge clk) rst_n = 1'b1;
      tick;

      // static rm, done two cycles after the start pulse
      snap_w = wen_cnt; snap_s = start_cnt;
      issue(4'h5, 5'd3, 5'd4, 5'd0, 3'b001);
      chk("rd_busy", busy, 1);
      chk("rd_rs1", f_rs1, 5'd3);
      chk("rd_rs2", f_rs2, 5'd4);
      chk("rd_ready", issue_ready, 0);
      tick;
      chk("ex1_start", exe_start, 1);
      chk("ex1_a", exe_a, 32'hA000_0003);
      chk("ex1_b", exe_b, 32'hB000_0004);
      chk("ex1_rm", exe_rm, 3'b001);
      chk("ex1_op", exe_op, 4'h5);
      tick;
      chk("ex2_start", exe_start, 0);
      chk("ex2_wen", f_wen, 0);
      tick;
      exe_done = 1; exe_result = 32'h3F80_0000; exe_flags = 5'b00001;
      chk("ex3_a_stable", exe_a, 32'hA000_0003);
      tick;
      exe_done = 0; exe_result = 0; exe_flags = 0;
      chk("wb_wen", f_wen, 1);
      chk("wb_rd", f_rd, 5'd0);
      chk("wb_data", f_w_data, 32'h3F80_0000);
      chk("wb_flags", {f_NV, f_DZ, f_OF, f_UF, f_NX}, 5'b00001);
      tick;
      chk("post_wen", f_wen, 0);
      chk("post_wdata", f_w_data, 0);
      chk("post_nx", f_NX, 0);
      chk("post_ready", issue_ready, 1);
      chk("wen_pulses", wen_cnt - snap_w, 1);
      chk("start_pulses", start_cnt - snap_s, 1);

      // dynamic rm resolves from frm; done in the first EXEC cycle -> wen in cycle 3
      f_frm_out = 3'b010;
      issue(4'h2, 5'd7, 5'd31, 5'd9, 3'b111);
      tick;
      chk("dyn_rm", exe_rm, 3'b010);
      exe_done = 1; exe_result = 32'h4000_0000; exe_flags = 5'b10100;
      tick;
      exe_done = 0;
      chk("fast_wen", f_wen, 1);
      chk("fast_rd", f_rd, 5'd9);
      chk("fast_flags", {f_NV, f_DZ, f_OF, f_UF, f_NX}, 5'b10100);
      tick;

      // dynamic rm resolving to reserved 5 aborts with no write
      snap_w = wen_cnt; snap_s = start_cnt;
      f_frm_out = 3'b101;
      issue(4'h1, 5'd1, 5'd2, 5'd3, 3'b111);
      tick;
      chk("ill_pulse", illegal_rm, 1);
      chk("ill_ready", issue_ready, 1);
      chk("ill_wen", f_wen, 0);
      tick;
      chk("ill_clear", illegal_rm, 0);
      // static reserved rm 6
      f_frm_out = 3'b000;
      issue(4'h1, 5'd1, 5'd2, 5'd3, 3'b110);
      tick;
      chk("ill6_pulse", illegal_rm, 1);
      tick;
      chk("ill_no_wen", wen_cnt - snap_w, 0);
      chk("ill_no_start", start_cnt - snap_s, 0);

      // back-to-back: valid and done held high, one accept every 4 cycles
      issue_valid = 1; issue_rm = 3'b000; issue_rd = 5'd4; issue_rs1 = 5'd5; issue_rs2 = 5'd6;
      exe_done = 1; exe_result = 32'h1234_5678; exe_flags = 0;
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("tp_ready%0d", i), issue_ready, (i % 4 == 0) ? 1 : 0);
         chk($sformatf("tp_wen%0d", i), f_wen, (i % 4 == 3) ? 1 : 0);
         tick;
      end
      issue_valid = 0; exe_done = 0;
      tick; tick; tick; tick;
      chk("tp_idle", issue_ready, 1);

      // reset during EXEC aborts immediately
      snap_w = wen_cnt;
      issue(4'h7, 5'd10, 5'd11, 5'd12, 3'b011);
      tick;
      chk("pre_rst_start", exe_start, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_start", exe_start, 0);
      chk("ar_busy", busy, 0);
      chk("ar_ready", issue_ready, 1);
      chk("ar_a", exe_a, 0);
      chk("ar_rm", exe_rm, 0);
      chk("ar_rs1", f_rs1, 0);
      exe_done = 1; exe_result = 32'hDEAD_BEEF;
      @(negedge clk) rst_n = 1'b1;
      tick; tick; tick;
      exe_done = 0;
      chk("ar_no_wen", wen_cnt - snap_w, 0);
      chk("ar_ready2", issue_ready, 1);

`ifdef FPU_RF_SEQ_WATCHDOG_EN
      // done never comes: timeout after 4 EXEC cycles
      snap_w = wen_cnt;
      issue(4'h3, 5'd1, 5'd1, 5'd2, 3'b000);
      tick;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wd_busy%0d", i), busy, 1);
         tick;
      end
      chk("wd_tmo", exe_timeout, 1);
      chk("wd_ready", issue_ready, 1);
      tick;
      chk("wd_tmo_clr", exe_timeout, 0);
      chk("wd_no_wen", wen_cnt - snap_w, 0);
      // done on the expiry cycle wins
      issue(4'h3, 5'd1, 5'd1, 5'd2, 3'b000);
      tick; tick; tick; tick;
      exe_done = 1; exe_result = 32'h0BAD_F00D;
      tick;
      exe_done = 0;
      chk("wd_late_wen", f_wen, 1);
      chk("wd_late_data", f_w_data, 32'h0BAD_F00D);
      chk("wd_late_tmo", exe_timeout, 0);
      tick;
      chk("wd_late_tmo2", exe_timeout, 0);
`else
      // no watchdog: EXEC waits past any limit
      issue(4'h3, 5'd1, 5'd1, 5'd2, 3'b000);
      tick;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("nowd_tmo%0d", i), exe_timeout, 0);
         tick;
      end
      chk("nowd_busy", busy, 1);
      exe_done = 1; exe_result = 32'h0BAD_F00D;
      tick;
      exe_done = 0;
      chk("nowd_wen", f_wen, 1);
      chk("nowd_data", f_w_data, 32'h0BAD_F00D);
      tick;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
